// File: rtl/dlx_pkg.sv
// dlx_pkg: shared widths and arbiter state encoding for the DLX memory slice
package dlx_pkg;

    localparam int DLX_ADDR_W = 32;
    localparam int DLX_DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT_I = 2'd1,
        GRANT_D = 2'd2
    } arb_state_t;

endpackage

// File: rtl/dlx_mem_arbiter.sv
// dlx_mem_arbiter: shares one single-port memory between DLX fetch and data sides with a watchdog
module dlx_mem_arbiter
    import dlx_pkg::*;
#(
    parameter int ADDR_W      = DLX_ADDR_W,
    parameter int DATA_W      = DLX_DATA_W,
    parameter int MAX_D_BURST = 4,
    parameter int TIMEOUT     = 256
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_address,
    output logic [DATA_W-1:0] i_data_read,
    output logic              i_data_valid,
    input  logic              d_req,
    input  logic [ADDR_W-1:0] d_address,
    input  logic [DATA_W-1:0] d_data_write,
    input  logic              d_write_enable,
    output logic [DATA_W-1:0] d_data_read,
    output logic              d_data_valid,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_data_write,
    output logic              mem_write_enable,
    input  logic [DATA_W-1:0] mem_data_read,
    input  logic              mem_data_valid,
    output logic              mem_timeout
);

    localparam int WD_W = $clog2(TIMEOUT);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);
    localparam logic [3:0] CAP = 4'(MAX_D_BURST);

    arb_state_t state, state_n;
    logic [3:0] streak, streak_n;
    logic [WD_W-1:0] wdog, wdog_n;
    logic [DATA_W-1:0] i_data_read_n, d_data_read_n, mem_data_write_n, rdata;
    logic [ADDR_W-1:0] mem_address_n;
    logic i_data_valid_n, d_data_valid_n, mem_req_n, mem_write_enable_n, mem_timeout_n;
    logic i_elig, d_elig;

    // a side that is pulsing its valid this cycle is dropping its req, so it is not re-issued
    assign i_elig = i_req && !i_data_valid;
    assign d_elig = d_req && !d_data_valid;

    // next-state and registered-output values: arbitration in IDLE, completion or abort in a grant
    always_comb begin
        state_n = state;
        streak_n = streak;
        wdog_n = wdog;
        i_data_read_n = i_data_read;
        i_data_valid_n = 1'b0;
        d_data_read_n = d_data_read;
        d_data_valid_n = 1'b0;
        mem_req_n = mem_req;
        mem_address_n = mem_address;
        mem_data_write_n = mem_data_write;
        mem_write_enable_n = mem_write_enable;
        mem_timeout_n = mem_timeout;
        rdata = mem_data_valid ? mem_data_read : '0;
        if (state == IDLE) begin
            if (!i_req) streak_n = '0;
            if (d_elig && !(i_elig && streak == CAP)) begin
                state_n = GRANT_D;
                mem_req_n = 1'b1;
                mem_address_n = d_address;
                mem_data_write_n = d_data_write;
                mem_write_enable_n = d_write_enable;
                wdog_n = '0;
                streak_n = i_req ? streak + 4'd1 : '0;
            end else if (i_elig) begin
                state_n = GRANT_I;
                mem_req_n = 1'b1;
                mem_address_n = i_address;
                mem_data_write_n = '0;
                mem_write_enable_n = 1'b0;
                wdog_n = '0;
                streak_n = '0;
            end
        end else if (mem_data_valid || wdog == WD_LAST) begin
            state_n = IDLE;
            mem_req_n = 1'b0;
            mem_timeout_n = mem_timeout || !mem_data_valid;
            if (state == GRANT_I) begin
                i_data_valid_n = 1'b1;
                i_data_read_n = rdata;
            end else begin
                d_data_valid_n = 1'b1;
                d_data_read_n = mem_write_enable ? '0 : rdata;
            end
        end else begin
            wdog_n = wdog + 1'b1;
        end
    end

    // state and output registers, cleared asynchronously by reset
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            streak <= '0;
            wdog <= '0;
            i_data_read <= '0;
            i_data_valid <= 1'b0;
            d_data_read <= '0;
            d_data_valid <= 1'b0;
            mem_req <= 1'b0;
            mem_address <= '0;
            mem_data_write <= '0;
            mem_write_enable <= 1'b0;
            mem_timeout <= 1'b0;
        end else begin
            state <= state_n;
            streak <= streak_n;
            wdog <= wdog_n;
            i_data_read <= i_data_read_n;
            i_data_valid <= i_data_valid_n;
            d_data_read <= d_data_read_n;
            d_data_valid <= d_data_valid_n;
            mem_req <= mem_req_n;
            mem_address <= mem_address_n;
            mem_data_write <= mem_data_write_n;
            mem_write_enable <= mem_write_enable_n;
            mem_timeout <= mem_timeout_n;
        end
    end

endmodule
